// File: rtl/serial_capture_8.sv
// serial_capture_8: serial-in/parallel-out word capture with valid/ack handoff (optional SERIAL_CAPTURE_PARITY_EN adds a parity guard bit and o_parity_err)
module serial_capture_8 #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_shift_en,
  input  logic             i_bit_in,
  input  logic             i_word_ack,
  output logic [WIDTH-1:0] o_word_out,
  output logic             o_word_valid,
  output logic             o_busy,
  output logic [3:0]       o_count,
  output logic             o_overrun
`ifdef SERIAL_CAPTURE_PARITY_EN
  ,
  output logic             o_parity_err
`endif
);
  typedef enum logic [1:0] {IDLE, CAPTURE, GUARD} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shift, r_word, w_shift_next, w_word_new;
  logic [3:0]       r_count;
  logic             r_valid, r_overrun;
  logic             w_last_data, w_complete, w_load, w_drop;
  assign w_shift_next = LSB_FIRST ? {i_bit_in, r_shift[WIDTH-1:1]} : {r_shift[WIDTH-2:0], i_bit_in};
  assign w_last_data  = r_state == CAPTURE && i_shift_en && r_count == 4'(WIDTH - 1);
`ifdef SERIAL_CAPTURE_PARITY_EN
  localparam state_t AFTER_DATA = GUARD;
  logic r_parity_err, w_parity_new;
  assign w_complete   = r_state == GUARD && i_shift_en;
  assign w_word_new   = r_shift;
  assign w_parity_new = (^r_shift) ^ i_bit_in;
  assign o_parity_err = r_parity_err;
`else
  localparam state_t AFTER_DATA = IDLE;
  assign w_complete = w_last_data;
  assign w_word_new = w_shift_next;
`endif
  assign w_load       = w_complete && (!r_valid || i_word_ack);
  assign w_drop       = w_complete && r_valid && !i_word_ack;
  assign o_word_out   = r_word;
  assign o_word_valid = r_valid;
  assign o_busy       = r_state != IDLE;
  assign o_count      = r_count;
  assign o_overrun    = r_overrun;
  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end
  // Next state: arm on Start in IDLE, leave CAPTURE after the last data bit, leave GUARD on the parity bit
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && i_start) w_next = CAPTURE;
    else if (w_last_data)           w_next = AFTER_DATA;
    else if (w_complete)            w_next = IDLE;
  end
  // Shift register and bit counter; the count drops back to 0 on the completing bit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_complete) begin
      r_count <= '0;
    end else if (r_state == CAPTURE && i_shift_en) begin
      r_shift <= w_shift_next;
      r_count <= r_count + 4'd1;
    end
  end
  // Output word handoff: load when the slot is free or being acked, otherwise drop and flag overrun
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_word  <= w_word_new;
        r_valid <= 1'b1;
`ifdef SERIAL_CAPTURE_PARITY_EN
        r_parity_err <= w_parity_new;
`endif
      end else if (i_word_ack) begin
        r_valid <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end
endmodule

// File: doc/serial_capture_8.md
Name: serial_capture_8

Overview:
Bit-serial receive end of the register-unit shift path. It collects bits shifted out of the 8-bit register unit (one per Shift_En cycle) and reassembles them into a parallel word. The word is then handed to a downstream consumer, such as the hex display path or a result register, over a valid/ack handshake. The capture FSM mirrors the 8-cycle control sequencing, with the data flowing in the other direction: serial in, parallel out.

Parameters:
WIDTH, 8, bits per captured word (2..15).
LSB_FIRST, 1, 1 = first received bit lands in Word_out[0]; 0 = first received bit lands in Word_out[WIDTH-1].

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Start  input  1  single-cycle pulse that arms a capture.
Shift_En  input  1  qualifies Bit_In this cycle.
Bit_In  input  1  serial data bit.
Word_ack  input  1  consumer accepts Word_out this cycle.
Word_out  output  WIDTH  assembled word, held stable while Word_valid=1.
Word_valid  output  1  Word_out holds an unconsumed word.
Busy  output  1  FSM is in CAPTURE.
Count  output  4  bits captured so far in the current word.
Overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (Reset_n=0, asynchronous): FSM goes to IDLE. Word_out, Count, the shift register and Overrun are all cleared to 0. Word_valid=0, Busy=0.
- Reset mid-capture aborts the capture. Partial bits are discarded and no word is produced.
- FSM states: IDLE and CAPTURE (plus GUARD when the optional feature is compiled in).
- IDLE:
  - Start=1 -> CAPTURE next cycle; shift register and Count cleared.
  - Shift_En is ignored.
- CAPTURE:
  - Each cycle with Shift_En=1, Bit_In is shifted into the shift register and Count increments.
  - Cycles with Shift_En=0 hold all state; gaps between bits are allowed.
  - Start is ignored.
  - The shift that brings Count to WIDTH completes the word.
- Word completion, decided in the completion cycle:
  - Word_valid=0, or Word_valid=1 with Word_ack=1 in that cycle: the new word loads into Word_out and Word_valid=1 on the next edge.
  - Word_valid=1 with Word_ack=0: the new word is dropped, the old Word_out is kept, and Overrun is set.
  - Either way the FSM returns to IDLE and Count returns to 0.
- Latency: Word_out and Word_valid update on the clock edge after the final Shift_En cycle.
- Handshake:
  - Word_ack=1 while Word_valid=1 clears Word_valid on the next edge, unless a new word loads in the same cycle, in which case Word_valid stays 1.
  - Word_ack while Word_valid=0 has no effect.
  - A new capture may be armed and run while a previous word is still pending.
- Overrun clears only on reset.
- Bit order:
  - LSB_FIRST=1: the register shifts right; bit k received goes to Word_out[k].
  - LSB_FIRST=0: the register shifts left; bit k received goes to Word_out[WIDTH-1-k].
- Simultaneous Start and completion cannot occur, because Start is only honoured in IDLE.

Optional Feature:
Macro: SERIAL_CAPTURE_PARITY_EN.
- When defined:
  - After WIDTH data bits the FSM enters GUARD and takes one more Shift_En bit as an even-parity bit covering the data bits.
  - Completion happens on the parity bit.
  - An extra output Parity_err (1 bit, reset 0) loads together with Word_out: 1 if the XOR of the data bits and the parity bit is 1.
  - Parity_err is held alongside Word_out and follows the same drop rule on overrun.
- When undefined: there is no GUARD state, no Parity_err port, and completion happens on data bit WIDTH.

Test Plan:
1. Reset_n=0 mid-capture after 3 bits, then released -> Busy=0, Count=0, Word_valid=0, Word_out=0x00, Overrun=0.
2. LSB_FIRST=1: Start, then bits 0,1,1,1,1,0,0,0 on 8 consecutive Shift_En cycles -> Word_out=0x1E and Word_valid=1 one cycle after the last shift; Busy=0.
3. LSB_FIRST=0: same stream -> Word_out=0x78. Repeat with Shift_En idle gaps of 1-3 cycles between bits -> same result.
4. Capture 0x1E, no ack, then capture 0xFF -> Overrun=1, Word_out stays 0x1E. Repeat with Word_ack asserted in the completion cycle -> Word_out=0xFF, Word_valid stays 1, Overrun unchanged.
5. Shift_En pulses in IDLE, and Start pulsed during CAPTURE -> ignored; Count and Word_out unchanged.
6. SERIAL_CAPTURE_PARITY_EN defined: 0x1E followed by parity 0 -> Parity_err=0. Same word followed by parity 1 -> Parity_err=1, Word_out=0x1E in both cases.
